// File: rtl/sobel_pkg.sv
// ============================================================================
// Module      : sobel_pkg
// Description : Shared types and constants for the Sobel window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CALC_LATENCY = 4;
    localparam int PIX_W_DEF    = 8;

    // Interior positions only: the one-pixel border never produces a window.
    function automatic logic [31:0] windows_per_frame(input int img_w, input int img_h);
        return 32'((img_w - 2) * (img_h - 2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_window_ctrl_if.sv
// ============================================================================
// Module      : sobel_window_ctrl_if
// Description : Pixel stream in, 3x3 window out, calc done return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sobel_window_ctrl_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_i;
    logic             pix_valid_i;
    logic             pix_ready_o;
    logic [PIX_W-1:0] d0_o, d1_o, d2_o;
    logic [PIX_W-1:0] d3_o, d4_o, d5_o;
    logic [PIX_W-1:0] d6_o, d7_o, d8_o;
    logic             win_valid_o;
    logic             calc_done_i;

    modport slave (
        input  pix_i, pix_valid_i, calc_done_i,
        output pix_ready_o, win_valid_o,
        output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o
    );

    modport master (
        output pix_i, pix_valid_i, calc_done_i,
        input  pix_ready_o, win_valid_o,
        input  d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o
    );
endinterface

`default_nettype wire

// File: rtl/sobel_line_buf.sv
// ============================================================================
// Module      : sobel_line_buf
// Description : One row of pixel storage; async read, sync write, one port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] addr,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/sobel_window_ctrl.sv
// ============================================================================
// Module      : sobel_window_ctrl
// Description : Frame sequencer building 3x3 windows for the Sobel calc stage.
//               Optional stall counter port enabled by SOBEL_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = PIX_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start_i,
    sobel_window_ctrl_if.slave bus,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic [31:0]        out_cnt_o
`ifdef SOBEL_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);
    localparam logic [31:0]        c_win_total = windows_per_frame(IMG_W, IMG_H);

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_run   = RUN;
    localparam logic [1:0] c_st_drain = DRAIN;
    localparam logic [1:0] c_st_done  = DONE;

    logic [1:0]         r_state;
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [PIX_W-1:0]   r_win [9];
    logic               r_win_valid;
    logic [31:0]        r_out_cnt;

    logic               w_accept;
    logic               w_start;
    logic               w_last_pix;
    logic               w_win_pos;
    logic               w_count_done;
    logic [PIX_W-1:0]   w_lb0_rd;
    logic [PIX_W-1:0]   w_lb1_rd;

    assign w_accept     = bus.pix_valid_i && (r_state == c_st_run);
    assign w_start      = (r_state == c_st_idle) && start_i;
    assign w_last_pix   = w_accept && (r_col == c_col_last) && (r_row == c_row_last);
    assign w_win_pos    = (r_row >= c_row_two) && (r_col >= c_col_two);
    assign w_count_done = bus.calc_done_i &&
                          ((r_state == c_st_run) || (r_state == c_st_drain));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (start_i) r_state <= c_st_run;
                c_st_run:   if (w_last_pix) r_state <= c_st_drain;
                c_st_drain: if (r_out_cnt == c_win_total) r_state <= c_st_done;
                c_st_done:  r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // lb1 holds row r-1 and lb0 row r-2 at the current column; rotate on accept.
    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col),
        .wdata (w_lb1_rd),
        .rdata (w_lb0_rd)
    );

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col),
        .wdata (bus.pix_i),
        .rdata (w_lb1_rd)
    );

    // Stale pixels shifted in across a row wrap are masked by the c>=2 gate.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= w_accept && w_win_pos;
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb0_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb1_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= bus.pix_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_out_cnt <= '0;
        end else if (w_count_done) begin
            r_out_cnt <= r_out_cnt + 32'd1;
        end
    end

`ifdef SOBEL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_st_run) && !bus.pix_valid_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    assign bus.pix_ready_o = (r_state == c_st_run);
    assign bus.win_valid_o = r_win_valid;
    assign bus.d0_o        = r_win[0];
    assign bus.d1_o        = r_win[1];
    assign bus.d2_o        = r_win[2];
    assign bus.d3_o        = r_win[3];
    assign bus.d4_o        = r_win[4];
    assign bus.d5_o        = r_win[5];
    assign bus.d6_o        = r_win[6];
    assign bus.d7_o        = r_win[7];
    assign bus.d8_o        = r_win[8];

    assign busy_o       = (r_state != c_st_idle);
    assign frame_done_o = (r_state == c_st_done);
    assign out_cnt_o    = r_out_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
// ============================================================================
// Module      : tb_sobel_window_ctrl
// Description : Scoreboard bench for sobel_window_ctrl (4x4 and 5x3 frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int WB   = 5;
    localparam int HB   = 3;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic busy_a, busy_b, fd_a, fd_b;
    logic [31:0] oc_a, oc_b;
`ifdef SOBEL_STALL_CNT_EN
    logic [31:0] stall_a, stall_b;
`endif

    always #5 clk = ~clk;

    sobel_window_ctrl_if #(.PIX_W(8)) ifa ();
    sobel_window_ctrl_if #(.PIX_W(8)) ifb ();

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_a),
        .bus          (ifa),
        .busy_o       (busy_a),
        .frame_done_o (fd_a),
        .out_cnt_o    (oc_a)
`ifdef SOBEL_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_a)
`endif
    );

    sobel_window_ctrl #(.IMG_W(WB), .IMG_H(HB), .PIX_W(8)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_b),
        .bus          (ifb),
        .busy_o       (busy_b),
        .frame_done_o (fd_b),
        .out_cnt_o    (oc_b)
`ifdef SOBEL_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_b)
`endif
    );

    // Calc stage stand-in: done returns CALC_LATENCY cycles after a window.
    logic [CALC_LATENCY-1:0] pipe_a = '0;
    logic [CALC_LATENCY-1:0] pipe_b = '0;
    always @(posedge clk) begin
        pipe_a <= {pipe_a[CALC_LATENCY-2:0], ifa.win_valid_o};
        pipe_b <= {pipe_b[CALC_LATENCY-2:0], ifb.win_valid_o};
    end
    assign ifa.calc_done_i = pipe_a[CALC_LATENCY-1];
    assign ifb.calc_done_i = pipe_b[CALC_LATENCY-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [71:0] win;
        int          at;
    } exp_t;

    exp_t        q_a[$];
    logic [71:0] q_b[$];
    logic [7:0]  img [NPIX];

    int strobes_a, strobes_b, fd_cnt_a, fd_cnt_b, fd_cyc_a;
    int last_acc_a, gaps_a;
    logic [31:0] oc_at_fd_a, oc_at_fd_b;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] ref_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[8*(dr*3+dc) +: 8] = img[(r - 2 + dr) * W + (c - 2 + dc)];
        return w;
    endfunction

    function automatic logic [71:0] win_a();
        return {ifa.d8_o, ifa.d7_o, ifa.d6_o, ifa.d5_o, ifa.d4_o,
                ifa.d3_o, ifa.d2_o, ifa.d1_o, ifa.d0_o};
    endfunction

    function automatic logic [71:0] win_b();
        return {ifb.d8_o, ifb.d7_o, ifb.d6_o, ifb.d5_o, ifb.d4_o,
                ifb.d3_o, ifb.d2_o, ifb.d1_o, ifb.d0_o};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ifa.win_valid_o) begin
            strobes_a++;
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win_a_unexpected: got strobe at cycle %0d expected none", cyc);
            end else begin
                e = q_a.pop_front();
                chk("win_a", win_a(), e.win);
                chk("win_a_cycle", 72'(cyc), 72'(e.at));
            end
        end
        if (fd_a) begin
            fd_cnt_a++;
            fd_cyc_a   = cyc;
            oc_at_fd_a = oc_a;
        end
        if (ifb.win_valid_o) begin
            strobes_b++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win_b_unexpected: got strobe at cycle %0d expected none", cyc);
            end else begin
                chk("win_b", win_b(), q_b.pop_front());
            end
        end
        if (fd_b) begin
            fd_cnt_b++;
            oc_at_fd_b = oc_b;
        end
    end

    // Drives one frame into A; abort_after stops after that many accepts.
    task automatic run_frame_a(input int gap_pct, input int restart_at,
                               input int abort_after, input bit rand_pix);
        int   idx, guard;
        exp_t e;
        for (int i = 0; i < NPIX; i++) img[i] = rand_pix ? 8'($urandom) : 8'(i);
        strobes_a = 0;
        fd_cnt_a  = 0;
        gaps_a    = 0;
        @(posedge clk) #1 start_a = 1'b1;
        @(posedge clk) #1 start_a = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < NPIX && idx != abort_after) begin
            start_a = (guard == restart_at);
            if (int'($urandom_range(99)) < gap_pct) begin
                ifa.pix_valid_i = 1'b0;
                gaps_a++;
            end else begin
                ifa.pix_valid_i = 1'b1;
                ifa.pix_i       = img[idx];
            end
            @(negedge clk);
            if (ifa.pix_valid_i && ifa.pix_ready_o) begin
                if (idx / W >= 2 && idx % W >= 2) begin
                    e.win = ref_win(idx / W, idx % W);
                    e.at  = cyc + 1;
                    q_a.push_back(e);
                end
                last_acc_a = cyc;
                idx++;
            end
            guard++;
            if (guard > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got %0d pixels expected %0d", idx, NPIX);
                break;
            end
            @(posedge clk) #1;
        end
        ifa.pix_valid_i = 1'b0;
        start_a         = 1'b0;
    endtask

    task automatic finish_frame_a(input string tag);
        int n = 0;
        while (fd_cnt_a == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_fd_pulses"}, 72'(fd_cnt_a), 72'(1));
        chk({tag, "_out_cnt"}, 72'(oc_at_fd_a), 72'(windows_per_frame(W, H)));
        chk({tag, "_fd_latency_ge6"}, 72'((fd_cyc_a - last_acc_a) >= 6), 72'(1));
        chk({tag, "_strobes"}, 72'(strobes_a), 72'((W - 2) * (H - 2)));
        chk({tag, "_queue_left"}, 72'(q_a.size()), 72'(0));
        chk({tag, "_busy_after"}, 72'(busy_a), 72'(0));
`ifdef SOBEL_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, 72'(stall_a), 72'(gaps_a));
`endif
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, 72'(busy_a), 72'(0));
        chk({tag, "_frame_done"}, 72'(fd_a), 72'(0));
        chk({tag, "_ready"}, 72'(ifa.pix_ready_o), 72'(0));
        chk({tag, "_win_valid"}, 72'(ifa.win_valid_o), 72'(0));
        chk({tag, "_window"}, win_a(), 72'(0));
        chk({tag, "_out_cnt"}, 72'(oc_a), 72'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.pix_valid_i = 1'b0;
        ifa.pix_i       = '0;
        ifb.pix_valid_i = 1'b0;
        ifb.pix_i       = '0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_a("reset");
        chk("reset_b_busy", 72'(busy_b), 72'(0));

        // Back-to-back ramp 0..15
        run_frame_a(0, -1, -1, 1'b0);
        finish_frame_a("ramp");

        // Random data with ~50% valid gaps
        run_frame_a(50, -1, -1, 1'b1);
        finish_frame_a("gaps");

        // start_i pulsed mid-frame must be ignored
        run_frame_a(30, 5, -1, 1'b1);
        finish_frame_a("restart");

        // Abort after pixel 7, then a clean rerun of the ramp
        run_frame_a(0, -1, 8, 1'b0);
        rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_a("abort");
        repeat (10) @(posedge clk);
        #1;
        run_frame_a(0, -1, -1, 1'b0);
        finish_frame_a("rerun");

        // 5x3 frame of constant 100
        strobes_b = 0;
        fd_cnt_b  = 0;
        @(posedge clk) #1 start_b = 1'b1;
        @(posedge clk) #1 start_b = 1'b0;
        for (int i = 0; i < WB * HB; i++) begin
            ifb.pix_valid_i = 1'b1;
            ifb.pix_i       = 8'd100;
            if (i / WB >= 2 && i % WB >= 2) q_b.push_back({9{8'd100}});
            @(posedge clk) #1;
        end
        ifb.pix_valid_i = 1'b0;
        n = 0;
        while (fd_cnt_b == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b_fd_pulses", 72'(fd_cnt_b), 72'(1));
        chk("b_strobes", 72'(strobes_b), 72'(3));
        chk("b_out_cnt", 72'(oc_at_fd_b), 72'(3));
        chk("b_busy_after", 72'(busy_b), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
